// File: rtl/stopwatch_timer_core.sv
// ---------------------------------------------------------------------------
// stopwatch_timer_core
//   Centisecond stopwatch datapath. A prescaler divides clk down to the
//   centisecond rate. The count is kept as six BCD digits, MM:SS.cc. When the
//   count reaches MAX_MINUTES:59.99 it saturates and raises a flag. The
//   controller supplies the run-enable and clear-command levels.
//
//   Optional feature macro: STOPWATCH_LAP_EN
//     When defined, a lap_capture_in pulse latches the current count into
//     lap_time_out. When undefined, the lap outputs are tied to 0.
// ---------------------------------------------------------------------------
module stopwatch_timer_core #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int MAX_MINUTES = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_run_en_in,
    input  logic        timer_reset_cmd_in,
    input  logic        lap_capture_in,
    output logic [23:0] time_bcd_out,
    output logic        cs_tick_out,
    output logic        max_time_reached_out,
    output logic [23:0] lap_time_out,
    output logic        lap_valid_out
);

    localparam int            DIV        = CLK_FREQ_HZ / TICK_HZ;
    localparam int            PW         = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] cs_t;
        logic [3:0] cs_o;
    } bcd_time_t;

    localparam bcd_time_t MAX_TIME = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10),
                                      4'd5, 4'd9, 4'd9, 4'd9};

    // Add one centisecond. Every digit carry resolves in this one step, so
    // 00:59.99 becomes 01:00.00 on a single edge. The minutes never go past
    // MAX_MINUTES because the count saturates there.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.cs_o != 4'd9) begin
            n.cs_o = t.cs_o + 4'd1;
        end else begin
            n.cs_o = 4'd0;
            if (t.cs_t != 4'd9) begin
                n.cs_t = t.cs_t + 4'd1;
            end else begin
                n.cs_t = 4'd0;
                if (t.sec_o != 4'd9) begin
                    n.sec_o = t.sec_o + 4'd1;
                end else begin
                    n.sec_o = 4'd0;
                    if (t.sec_t != 4'd5) begin
                        n.sec_t = t.sec_t + 4'd1;
                    end else begin
                        n.sec_t = 4'd0;
                        if (t.min_o != 4'd9) begin
                            n.min_o = t.min_o + 4'd1;
                        end else begin
                            n.min_o = 4'd0;
                            n.min_t = t.min_t + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    bcd_time_t     time_q,  time_d;
    logic          tick_q,  tick_d;
    logic          max_q,   max_d;

    // Next-state logic. Priority is clear command, then saturation, then counting, then hold.
    always_comb begin
        // NOTE: every signal gets a default before any branch. A path that
        // leaves a signal unassigned would infer a latch.
        presc_d = presc_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        max_d   = max_q;
        if (timer_reset_cmd_in) begin
            presc_d = '0;
            time_d  = '0;
            max_d   = 1'b0;
        end else if (max_q) begin
            presc_d = '0;
        end else if (timer_run_en_in) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                time_d  = bcd_inc(time_q);
                tick_d  = 1'b1;
                max_d   = (time_d == MAX_TIME);
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // State registers. Reset is synchronous and takes priority over everything else.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge.
        if (reset) begin
            presc_q <= '0;
            time_q  <= '0;
            tick_q  <= 1'b0;
            max_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            max_q   <= max_d;
        end
    end

    assign time_bcd_out         = time_q;
    assign cs_tick_out          = tick_q;
    assign max_time_reached_out = max_q;

`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap_q;
    logic        lap_valid_q;

    // Lap capture. It latches the pre-increment count, and a later capture overwrites it.
    always_ff @(posedge clk) begin
        if (reset || timer_reset_cmd_in) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (lap_capture_in) begin
            lap_q       <= time_q;
            lap_valid_q <= 1'b1;
        end
    end

    assign lap_time_out  = lap_q;
    assign lap_valid_out = lap_valid_q;
`else
    // The lap feature is compiled out. The input is deliberately left unused.
    logic lap_capture_unused;
    assign lap_capture_unused = lap_capture_in;
    assign lap_time_out       = '0;
    assign lap_valid_out      = 1'b0;
`endif

endmodule
